// File: rtl/alive_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alive_pkg                                                          |
// | Shared note table and FSM state type for the tone decoder.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alive_pkg;

    localparam int NUM_NOTES = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        SEARCH = 2'd2,
        REPORT = 2'd3
    } state_e;

    // Expected rising edges of octave-4 notes over a 250 ms gate.
    function automatic logic [7:0] note_edges(input logic [3:0] idx);
        logic [7:0] edges;
        case (idx)
            4'd0:    edges = 8'd65;
            4'd1:    edges = 8'd69;
            4'd2:    edges = 8'd73;
            4'd3:    edges = 8'd78;
            4'd4:    edges = 8'd82;
            4'd5:    edges = 8'd87;
            4'd6:    edges = 8'd92;
            4'd7:    edges = 8'd98;
            4'd8:    edges = 8'd104;
            4'd9:    edges = 8'd110;
            4'd10:   edges = 8'd116;
            4'd11:   edges = 8'd123;
            default: edges = 8'd0;
        endcase
        return edges;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_timebase.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ms_timebase                                                        |
// | Prescaler producing a one-cycle tick every millisecond.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ms_timebase (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ticks_per_milli,
    output logic        ms_tick
);

    logic [15:0] presc_q, presc_d;
    logic [15:0] lim_q, lim_d;
    logic [15:0] lim_now;

    // The period length is sampled at the start of each millisecond so a
    // rate change never truncates or stretches the one in progress.
    always_comb begin
        lim_now = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
        lim_d   = (presc_q == 16'd0) ? lim_now : lim_q;
        ms_tick = (presc_q == (lim_d - 16'd1));
        presc_d = ms_tick ? 16'd0 : (presc_q + 16'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            lim_q   <= 16'd1;
        end else begin
            presc_q <= presc_d;
            lim_q   <= lim_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tone_decoder                                                       |
// | Counts square-wave edges per gate and classifies against a table.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tone_decoder
    import alive_pkg::*;
#(
    parameter int GATE_MS   = 250,
    parameter int TOL       = 1,
    parameter int MIN_EDGES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ticks_per_milli,
    input  logic        sound_in,
    output logic [3:0]  note_idx,
    output logic        note_valid,
    output logic        note_hit,
    output logic        silence,
    output logic [7:0]  edge_count
);

    localparam logic [15:0]       C_GATE_LAST = 16'(GATE_MS - 1);
    localparam logic [7:0]        C_MIN       = 8'(MIN_EDGES);
    localparam logic signed [8:0] C_TOL       = 9'(TOL);
    localparam logic [3:0]        C_LAST_IDX  = 4'(NUM_NOTES - 1);

    logic        ms_tick;
    logic        sync1_q, sync2_q, prev_q;
    logic        edge_det, gate_end, hit_now, silent_now;
    logic signed [8:0] diff, adiff;

    logic [15:0] ms_cnt_q, ms_cnt_d;
    logic [7:0]  live_q, live_d;
    logic [7:0]  cap_q, cap_d;
    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  note_idx_q, note_idx_d;
    logic        note_valid_q, note_valid_d;
    logic        note_hit_q, note_hit_d;
    logic        silence_q, silence_d;
    logic [7:0]  edge_count_q, edge_count_d;

    ms_timebase u_timebase (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (ticks_per_milli),
        .ms_tick         (ms_tick)
    );

    always_comb begin
        edge_det = sync2_q & ~prev_q;
        gate_end = ms_tick && (ms_cnt_q == C_GATE_LAST);

        ms_cnt_d = ms_cnt_q;
        if (ms_tick) begin
            ms_cnt_d = gate_end ? 16'd0 : (ms_cnt_q + 16'd1);
        end

        // An edge on the boundary cycle belongs to the gate that is starting.
        if (gate_end) begin
            live_d = {7'd0, edge_det};
            cap_d  = live_q;
        end else begin
            live_d = (edge_det && (live_q != 8'hFF)) ? (live_q + 8'd1) : live_q;
            cap_d  = cap_q;
        end

        diff       = $signed({1'b0, cap_q}) - $signed({1'b0, note_edges(idx_q)});
        adiff      = diff[8] ? -diff : diff;
        hit_now    = (adiff <= C_TOL);
        silent_now = (cap_q < C_MIN);

        state_d      = state_q;
        idx_d        = idx_q;
        note_idx_d   = note_idx_q;
        note_valid_d = 1'b0;
        note_hit_d   = note_hit_q;
        silence_d    = silence_q;
        edge_count_d = edge_count_q;

        case (state_q)
            IDLE: state_d = GATE;
            GATE: begin
                if (gate_end) begin
                    state_d = SEARCH;
                    idx_d   = 4'd0;
                end
            end
            SEARCH: begin
                if (silent_now || hit_now || (idx_q == C_LAST_IDX)) begin
                    state_d      = REPORT;
                    note_valid_d = 1'b1;
                    edge_count_d = cap_q;
                    silence_d    = silent_now;
                    note_hit_d   = hit_now && !silent_now;
                    if (hit_now && !silent_now) begin
                        note_idx_d = idx_q;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            REPORT: state_d = GATE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            ms_cnt_q     <= 16'd0;
            live_q       <= 8'd0;
            cap_q        <= 8'd0;
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            note_idx_q   <= 4'd0;
            note_valid_q <= 1'b0;
            note_hit_q   <= 1'b0;
            silence_q    <= 1'b1;
            edge_count_q <= 8'd0;
        end else begin
            sync1_q      <= sound_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            ms_cnt_q     <= ms_cnt_d;
            live_q       <= live_d;
            cap_q        <= cap_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            note_idx_q   <= note_idx_d;
            note_valid_q <= note_valid_d;
            note_hit_q   <= note_hit_d;
            silence_q    <= silence_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign note_idx   = note_idx_q;
    assign note_valid = note_valid_q;
    assign note_hit   = note_hit_q;
    assign silence    = silence_q;
    assign edge_count = edge_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tone_decoder                                                    |
// | Gate-by-gate edge patterns checked against a note-table model.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_tone_decoder;

    localparam int T   = 4;
    localparam int P   = T * 250;
    localparam int W   = P - 20;
    localparam int NG1 = 27;

    typedef struct {
        int n;
        int x;
        int cnt;
        int idx;
        int hit;
        int sil;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sound_in = 1'b0;
    logic [15:0] ticks_per_milli = 16'(T);
    logic [3:0]  note_idx;
    logic        note_valid;
    logic        note_hit;
    logic        silence;
    logic [7:0]  edge_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit drv_en = 1'b0;
    bit mon_en = 1'b0;
    int ng = 0;
    int pulses = 0;
    int last_idx = 0;
    int mv, mk, ml;

    int notes [12] = '{65, 69, 73, 78, 82, 87, 92, 98, 104, 110, 116, 123};
    int gate_n [64];
    int gate_x [64];
    int exp_cnt [64];
    int exp_idx [64];
    int exp_hit [64];
    int exp_sil [64];
    bit got [64];
    vec_t tbl [17];

    always #5 clk = ~clk;

    tone_decoder #(.GATE_MS(250), .TOL(1), .MIN_EDGES(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ticks_per_milli (ticks_per_milli),
        .sound_in        (sound_in),
        .note_idx        (note_idx),
        .note_valid      (note_valid),
        .note_hit        (note_hit),
        .silence         (silence),
        .edge_count      (edge_count)
    );

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Gate k detects edges in cycles [(k-1)P-1, kP-1); a pulse driven in
    // cycle c is seen two cycles later, so offset o is relative to that window.
    function automatic bit want(input int c);
        int k, o, x, n;
        if (c < 0) return 1'b0;
        k = (c + 3) / P + 1;
        o = c + 3 - (k - 1) * P;
        if (k >= 64) return 1'b0;
        n = gate_n[k];
        if (o == P - 1 && gate_x[k] == 1) return 1'b1;
        if (o == 0 && k >= 2 && gate_x[k-1] == 2) return 1'b1;
        x = o - 5;
        if (n > 0 && x >= 0 && x < W && ((x * n + W - 1) / W) * W < (x + 1) * n)
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic void classify(input int n, inout int last,
                                     output int cnt, output int hit, output int sil);
        int d;
        cnt = (n > 255) ? 255 : n;
        sil = (cnt < 8) ? 1 : 0;
        hit = 0;
        if (sil == 0) begin
            for (int i = 0; i < 12; i++) begin
                d = cnt - notes[i];
                if (d < 0) d = -d;
                if (hit == 0 && d <= 1) begin
                    hit  = 1;
                    last = i;
                end
            end
        end
    endfunction

    initial forever begin
        @(negedge clk);
        sound_in = drv_en && want(cyc);
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en && rst_n && note_valid) begin
            mv = cyc;
            mk = mv / P;
            ml = mv - (mk * P - 1);
            checks++;
            if (mk < 1 || mk > ng) begin
                errors++;
                $display("FAIL stray_pulse: pulse at cycle %0d, required none", mv);
            end else begin
                if (ml < 1 || ml > 13) begin
                    errors++;
                    $display("FAIL latency g%0d: got %0d cycles required 1..13", mk, ml);
                end
                chk($sformatf("dup_pulse g%0d", mk), int'(got[mk]), 0);
                got[mk] = 1'b1;
                chk($sformatf("edge_count g%0d", mk), int'(edge_count), exp_cnt[mk]);
                chk($sformatf("note_idx g%0d", mk), int'(note_idx), exp_idx[mk]);
                chk($sformatf("note_hit g%0d", mk), int'(note_hit), exp_hit[mk]);
                chk($sformatf("silence g%0d", mk), int'(silence), exp_sil[mk]);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " note_idx"}, int'(note_idx), 0);
        chk({tag, " note_valid"}, int'(note_valid), 0);
        chk({tag, " note_hit"}, int'(note_hit), 0);
        chk({tag, " silence"}, int'(silence), 1);
        chk({tag, " edge_count"}, int'(edge_count), 0);
    endtask

    initial begin
        tbl[0]  = '{0,   0, 0,   0,  0, 1};
        tbl[1]  = '{110, 0, 110, 9,  1, 0};
        tbl[2]  = '{65,  0, 65,  0,  1, 0};
        tbl[3]  = '{70,  0, 70,  1,  1, 0};
        tbl[4]  = '{73,  0, 73,  2,  1, 0};
        tbl[5]  = '{12,  0, 12,  2,  0, 0};
        tbl[6]  = '{5,   0, 5,   2,  0, 1};
        tbl[7]  = '{300, 0, 255, 2,  0, 0};
        tbl[8]  = '{124, 0, 124, 11, 1, 0};
        tbl[9]  = '{66,  0, 66,  0,  1, 0};
        tbl[10] = '{7,   0, 7,   0,  0, 1};
        tbl[11] = '{8,   0, 8,   0,  0, 0};
        tbl[12] = '{64,  0, 64,  0,  1, 0};
        tbl[13] = '{67,  0, 67,  0,  0, 0};
        tbl[14] = '{62,  1, 63,  0,  0, 0};
        tbl[15] = '{71,  2, 71,  0,  0, 0};
        tbl[16] = '{63,  0, 64,  0,  1, 0};

        for (int k = 0; k < 64; k++) begin
            gate_n[k] = 0;
            gate_x[k] = 0;
            got[k]    = 1'b0;
        end
        for (int i = 0; i < 17; i++) begin
            gate_n[i+1]  = tbl[i].n;
            gate_x[i+1]  = tbl[i].x;
            exp_cnt[i+1] = tbl[i].cnt;
            exp_idx[i+1] = tbl[i].idx;
            exp_hit[i+1] = tbl[i].hit;
            exp_sil[i+1] = tbl[i].sil;
        end
        last_idx = 0;
        for (int k = 18; k <= NG1; k++) begin
            if ($urandom_range(0, 1) == 1)
                gate_n[k] = notes[$urandom_range(0, 11)] + int'($urandom_range(0, 4)) - 2;
            else
                gate_n[k] = int'($urandom_range(0, 140));
            classify(gate_n[k], last_idx, exp_cnt[k], exp_hit[k], exp_sil[k]);
            exp_idx[k] = last_idx;
        end
        gate_n[NG1+1] = 110;
        ng = NG1;

        repeat (4) @(negedge clk);
        rst_n  = 1'b1;
        drv_en = 1'b1;
        mon_en = 1'b1;
        #1;
        check_reset_outputs("reset");

        while (cyc < NG1 * P + 20) @(negedge clk);
        mon_en = 1'b0;
        for (int k = 1; k <= NG1; k++)
            chk($sformatf("pulse_seen g%0d", k), int'(got[k]), 1);

        // Abort gate 28 while its search is still walking the table.
        while (cyc < (NG1 + 1) * P + 4) @(negedge clk);
        rst_n  = 1'b0;
        drv_en = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (note_valid) pulses++;
        end
        for (int k = 0; k < 64; k++) begin
            gate_n[k] = 0;
            gate_x[k] = 0;
            got[k]    = 1'b0;
        end
        gate_n[1]  = 98;
        exp_cnt[1] = 98;
        exp_idx[1] = 7;
        exp_hit[1] = 1;
        exp_sil[1] = 0;
        ng = 1;
        rst_n  = 1'b1;
        drv_en = 1'b1;
        #1;
        check_reset_outputs("midsearch_reset");
        repeat (20) begin
            @(negedge clk);
            #1;
            if (note_valid) pulses++;
        end
        chk("no_pulse_after_abort", pulses, 0);
        mon_en = 1'b1;
        while (cyc < P + 20) @(negedge clk);
        mon_en = 1'b0;
        chk("pulse_seen fresh_gate", int'(got[1]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
